// File: rtl/mips_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding, NOP word,
// opcode field position and PC increment.
package mips_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } fetch_state_t;

    localparam logic [31:0] INSTR_NOP  = 32'h0000_0000;
    localparam int          OPCODE_MSB = 31;
    localparam int          OPCODE_LSB = 26;
    localparam int          PC_INC     = 4;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Priority: reset > flush > load > hold.
// A flush leaves pc_plus4 alone and forces the instruction to NOP.
module if_id_reg
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              flush_i,
    input  logic [31:0]       instr_i,
    input  logic [ADDR_W-1:0] pc_plus4_i,
    output logic              valid_o,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] pc_plus4_o
);

    logic              r_valid;
    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_pc_plus4;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid    <= 1'b0;
            r_instr    <= INSTR_NOP;
            r_pc_plus4 <= '0;
        end else if (flush_i) begin
            r_valid    <= 1'b0;
            r_instr    <= INSTR_NOP;
        end else if (load_i) begin
            r_valid    <= 1'b1;
            r_instr    <= instr_i;
            r_pc_plus4 <= pc_plus4_i;
        end
    end

    assign valid_o    = r_valid;
    assign instr_o    = r_instr;
    assign pc_plus4_o = r_pc_plus4;

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: PC, imem request FSM, one-entry skid buffer, IF/ID feed to the decoder.
// Define FETCH_PERF_CNT_EN to add the perf_fetched_o / perf_stall_o counters.
module instr_fetch_stage
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [31:0]       imem_data_i,
    input  logic              stall_i,
    input  logic              branch_taken_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic              instr_valid_o,
    output logic [31:0]       instr_o,
    output logic [5:0]        instr_op_o,
    output logic [ADDR_W-1:0] pc_plus4_o,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]       perf_fetched_o,
    output logic [31:0]       perf_stall_o,
`endif
    output logic [1:0]        dbg_state_o
);

    // imem handshake: req stays high with a stable address until ack; the word
    // on imem_data_i transfers in the ack cycle and a request is never withdrawn.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_drain_addr;
    logic [31:0]       r_skid;

    logic              w_valid;
    logic              w_accept;
    logic              w_load;
    logic              w_flush;
    logic [31:0]       w_load_data;
    logic [ADDR_W-1:0] w_pc_next;

    assign w_accept  = !stall_i || !w_valid;
    assign w_pc_next = r_pc + ADDR_W'(PC_INC);

    always_comb begin
        w_load      = 1'b0;
        w_load_data = imem_data_i;
        if (!branch_taken_i) begin
            case (r_state)
                S_FETCH: w_load = imem_ack_i && w_accept;
                S_HOLD: begin
                    w_load      = w_accept;
                    w_load_data = r_skid;
                end
                default: w_load = 1'b0;
            endcase
        end
        // An accepted entry with nothing to replace it empties the register.
        w_flush = branch_taken_i || (w_accept && !w_load);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_drain_addr <= '0;
            r_skid       <= INSTR_NOP;
        end else if (branch_taken_i) begin
            r_pc   <= branch_target_i & ALIGN_MASK;
            r_skid <= INSTR_NOP;
            if (imem_req_o && !imem_ack_i) begin
                r_state      <= S_DRAIN;
                r_drain_addr <= imem_addr_o;
            end else begin
                r_state <= S_FETCH;
            end
        end else begin
            case (r_state)
                S_IDLE: r_state <= S_FETCH;
                S_FETCH: begin
                    if (imem_ack_i) begin
                        if (w_accept) begin
                            r_pc <= w_pc_next;
                        end else begin
                            r_skid  <= imem_data_i;
                            r_state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_accept) begin
                        r_pc    <= w_pc_next;
                        r_state <= S_FETCH;
                    end
                end
                S_DRAIN: if (imem_ack_i) r_state <= S_FETCH;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign imem_req_o  = (r_state == S_FETCH) || (r_state == S_DRAIN);
    assign imem_addr_o = (r_state == S_DRAIN) ? r_drain_addr : r_pc;
    assign dbg_state_o = r_state;

    if_id_reg #(.ADDR_W(ADDR_W)) u_if_id (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (w_load),
        .flush_i    (w_flush),
        .instr_i    (w_load_data),
        .pc_plus4_i (w_pc_next),
        .valid_o    (w_valid),
        .instr_o    (instr_o),
        .pc_plus4_o (pc_plus4_o)
    );

    assign instr_valid_o = w_valid;
    assign instr_op_o    = instr_o[OPCODE_MSB:OPCODE_LSB];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_load) r_perf_fetched <= r_perf_fetched + 32'd1;
            if (w_valid && stall_i) r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_fetched_o = r_perf_fetched;
    assign perf_stall_o   = r_perf_stall;
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage; memory returns word = address.
// Honors FETCH_PERF_CNT_EN to also check the performance counters.
module tb_instr_fetch_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ack_en;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;

  logic        req, ack, valid;
  logic [31:0] addr, data, instr, pp4;
  logic [5:0]  op;
  logic [1:0]  dbg_state;

  logic        w_req, w_ack, w_valid;
  logic        w_stall, w_br;
  logic [31:0] w_addr, w_data, w_instr, w_pp4, w_tgt;
  logic [5:0]  w_op;
  logic [1:0]  w_state;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall, w_perf_fetched, w_perf_stall;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    ack    = req && ack_en;
    data   = addr;
    w_ack  = w_req;
    w_data = w_addr;
  end

  instr_fetch_stage dut (
    .clk_i(clk), .rst_i(rst),
    .imem_req_o(req), .imem_addr_o(addr), .imem_ack_i(ack), .imem_data_i(data),
    .stall_i(stall), .branch_taken_i(br_taken), .branch_target_i(br_target),
    .instr_valid_o(valid), .instr_o(instr), .instr_op_o(op), .pc_plus4_o(pp4),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched_o(perf_fetched), .perf_stall_o(perf_stall),
`endif
    .dbg_state_o(dbg_state)
  );

  instr_fetch_stage #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk_i(clk), .rst_i(rst),
    .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_ack_i(w_ack), .imem_data_i(w_data),
    .stall_i(w_stall), .branch_taken_i(w_br), .branch_target_i(w_tgt),
    .instr_valid_o(w_valid), .instr_o(w_instr), .instr_op_o(w_op), .pc_plus4_o(w_pp4),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched_o(w_perf_fetched), .perf_stall_o(w_perf_stall),
`endif
    .dbg_state_o(w_state)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; ack_en = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = '0;
    w_stall = 1'b0; w_br = 1'b0; w_tgt = '0;
    tick(2);
    chk("rst_valid", valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pp4", pp4, 0);
    chk("rst_req", req, 0);
    chk("rst_state", dbg_state, S_IDLE);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf_fetched", perf_fetched, 0);
    chk("rst_perf_stall", perf_stall, 0);
`endif

    // Test 1: idle cycle, then back-to-back zero-wait fetches
    rst = 1'b0;
    tick(1);
    chk("idle_req", req, 1);
    chk("idle_addr", addr, 0);
    chk("idle_valid", valid, 0);
    chk("wrap_first_addr", w_addr, 32'hFFFF_FFFC);
    for (int k = 0; k < 3; k++) begin
      tick(1);
      chk("seq_valid", valid, 1);
      chk("seq_instr", instr, 4 * k);
      chk("seq_pp4", pp4, 4 * k + 4);
      if (k == 0) begin
        // Test 5: wrap instance fetched 0xFFFFFFFC, next address wraps to 0
        chk("wrap_instr", w_instr, 32'hFFFF_FFFC);
        chk("wrap_op", w_op, 6'h3F);
        chk("wrap_pp4", w_pp4, 0);
        chk("wrap_second_addr", w_addr, 0);
      end
    end

    // Test 2: three stall cycles, word 12 parked in the skid buffer
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      chk("stall_instr", instr, 8);
      chk("stall_pp4", pp4, 12);
      chk("stall_valid", valid, 1);
      chk("stall_state", dbg_state, S_HOLD);
      chk("stall_req", req, 0);
    end
    stall = 1'b0;
    tick(1);
    chk("release_instr", instr, 12);
    chk("release_pp4", pp4, 16);
    tick(1);
    chk("release_next_instr", instr, 16);
    chk("release_next_pp4", pp4, 20);

    // Test 3: redirect to 0x103 while ack for 20 is pending
    ack_en = 1'b0;
    tick(2);
    chk("pend_valid", valid, 0);
    chk("pend_addr", addr, 20);
    br_taken = 1'b1; br_target = 32'h103;
    tick(1);
    br_taken = 1'b0;
    chk("drain_state", dbg_state, S_DRAIN);
    chk("drain_req", req, 1);
    chk("drain_addr_stable", addr, 20);
    chk("drain_valid", valid, 0);
    tick(1);
    chk("drain_state2", dbg_state, S_DRAIN);
    ack_en = 1'b1;
    tick(1);
    chk("drained_valid", valid, 0);
    chk("drained_state", dbg_state, S_FETCH);
    chk("redirect_addr", addr, 32'h100);
    tick(1);
    chk("redirect_valid", valid, 1);
    chk("redirect_instr", instr, 32'h100);
    chk("redirect_pp4", pp4, 32'h104);

    // Test 4: redirect, stall and ack together; flush wins
    stall = 1'b1; br_taken = 1'b1; br_target = 32'h200;
    tick(1);
    stall = 1'b0; br_taken = 1'b0;
    chk("flush_valid", valid, 0);
    chk("flush_instr", instr, 0);
    chk("flush_addr", addr, 32'h200);
    chk("flush_state", dbg_state, S_FETCH);
    tick(1);
    chk("flush_next_instr", instr, 32'h200);
    chk("flush_next_valid", valid, 1);

    // Test 6: reset while holding a skid word
    stall = 1'b1;
    tick(1);
    chk("hold_state", dbg_state, S_HOLD);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, 7);
    chk("perf_stall", perf_stall, 5);
`endif
    rst = 1'b1;
    tick(1);
    rst = 1'b0; stall = 1'b0;
    chk("rst2_req", req, 0);
    chk("rst2_valid", valid, 0);
    chk("rst2_instr", instr, 0);
    chk("rst2_op", op, 0);
    chk("rst2_pp4", pp4, 0);
    chk("rst2_addr", addr, 0);
    chk("rst2_state", dbg_state, S_IDLE);
`ifdef FETCH_PERF_CNT_EN
    chk("rst2_perf_fetched", perf_fetched, 0);
    chk("rst2_perf_stall", perf_stall, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
